// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stalls, branch flushes and data-memory
// wait freezes with timeout, plus saturating stall/flush debug counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W       = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             pipe_freeze,
  output logic             mem_start,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {S_IDLE, S_WAIT} mem_state_t;

  mem_state_t        state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              timeout_set;
  logic              mem_busy;
  logic              hazard;

  // RAW check against both in-flight producers; no forwarding paths exist
  always_comb begin
    hazard = id_valid &
             ((exe_wb_en & (id_src1 == exe_dest)) |
              (mem_wb_en & (id_src1 == mem_dest)) |
              (id_two_src & exe_wb_en & (id_src2 == exe_dest)) |
              (id_two_src & mem_wb_en & (id_src2 == mem_dest)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Memory access sequencing; mem_start is Mealy in IDLE
  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    timeout_set = 1'b0;
    mem_busy    = 1'b0;
    mem_start   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mem_req) begin
          mem_start = 1'b1;
          mem_busy  = 1'b1;
          state_nxt = S_WAIT;
          wcnt_nxt  = '0;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_nxt = S_IDLE;
          wcnt_nxt  = '0;
        end else if (wcnt == WCNT_LAST) begin
          state_nxt   = S_IDLE;
          wcnt_nxt    = '0;
          timeout_set = 1'b1;
        end else begin
          mem_busy = 1'b1;
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        wcnt_nxt  = '0;
      end
    endcase
  end

  // Priority: memory freeze, then branch flush, then hazard stall
  always_comb begin
    pc_freeze    = 1'b0;
    if_id_freeze = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    pipe_freeze  = 1'b0;
    if (mem_busy) begin
      pc_freeze    = 1'b1;
      if_id_freeze = 1'b1;
      pipe_freeze  = 1'b1;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (hazard) begin
      pc_freeze    = 1'b1;
      if_id_freeze = 1'b1;
      id_exe_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_timeout <= 1'b0;
    end else if (timeout_set) begin
      mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pc_freeze && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (if_id_flush && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule
